// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: operation encodings and FSM states.
package shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 0..STEP bits for any of the four ops.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 8,
   parameter int AMT_W = $clog2(STEP) + 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [AMT_W-1:0] amt_i,
   input  op_e              op_i,
   output logic [WIDTH-1:0] data_o
);

   logic [2*WIDTH-1:0] rot_s;

   // Sign bit is preserved by each arithmetic step, so repeated SRA keeps the original fill.
   always_comb begin
      rot_s = {data_i, data_i} >> amt_i;
      case (op_i)
         OP_SLL:  data_o = data_i << amt_i;
         OP_SRL:  data_o = data_i >> amt_i;
         OP_SRA:  data_o = $signed(data_i) >>> amt_i;
         OP_ROR:  data_o = rot_s[WIDTH-1:0];
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: applies up to STEP bits of shift per clock until the full distance is covered.
module iterative_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int STEP    = 8,
   localparam int SHAMT_W = $clog2(WIDTH),
   localparam int AMT_W   = $clog2(STEP) + 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_out,
   output logic               busy
);

   generate
      if ((STEP < 1) || (STEP > WIDTH) || ((STEP & (STEP - 1)) != 0) ||
          (WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_params
         $error("iterative_shifter: illegal WIDTH/STEP combination");
      end
   endgenerate

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic               in_ready_q, out_valid_q, busy_q;
   logic [AMT_W-1:0]   step_amt_s;
   logic [WIDTH-1:0]   step_out_s;

   // Distance for this cycle: min(remaining, STEP).
   always_comb begin
      if ({1'b0, rem_q} >= (SHAMT_W + 1)'(STEP)) begin
         step_amt_s = AMT_W'(STEP);
      end else begin
         step_amt_s = AMT_W'(rem_q);
      end
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .AMT_W (AMT_W)
   ) u_step (
      .data_i (work_q),
      .amt_i  (step_amt_s),
      .op_i   (op_q),
      .data_o (step_out_s)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      work_d  = work_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = data_in;
               rem_d   = shamt;
               op_d    = op_e'(op);
               state_d = (shamt == {SHAMT_W{1'b0}}) ? DONE : SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d  = step_out_s;
            rem_d   = rem_q - SHAMT_W'(step_amt_s);
            state_d = (rem_d == {SHAMT_W{1'b0}}) ? DONE : SHIFT;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         op_q        <= OP_SLL;
         work_q      <= {WIDTH{1'b0}};
         rem_q       <= {SHAMT_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         work_q      <= work_d;
         rem_q       <= rem_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign data_out  = work_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (WIDTH=32, STEP=8): directed cases plus random ops vs. a reference model.
module tb_iterative_shifter;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   iterative_shifter #(.WIDTH(32), .STEP(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .shamt     (shamt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] o);
      logic [31:0] r;
      r = 32'd0;
      case (o)
         2'b00: r = d << s;
         2'b01: r = d >> s;
         2'b10: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? d[i + s] : d[31];
         default: for (int i = 0; i < 32; i++) r[i] = d[(i + s) % 32];
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o, input int hold);
      int lat;
      logic [31:0] exp_data;
      exp_data = ref_shift(d, int'(s), o);
      @(negedge clock);
      chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      data_in  = d;
      shamt    = s;
      op       = o;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'((int'(s) + 7) / 8));
      chk("data_out", {32'd0, data_out}, {32'd0, exp_data});
      chk("busy_done", {63'd0, busy}, 64'd1);
      for (int k = 0; k < hold; k++) begin
         @(negedge clock);
         in_valid = ~in_valid;
         data_in  = $urandom;
         shamt    = 5'($urandom_range(0, 31));
         @(posedge clock);
         #1;
         chk("hold_data", {32'd0, data_out}, {32'd0, exp_data});
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
         chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      end
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk("release_out_valid", {63'd0, out_valid}, 64'd0);
      chk("release_in_ready", {63'd0, in_ready}, 64'd1);
      chk("release_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = 32'd0;
      shamt     = 5'd0;
      op        = 2'b00;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_data_out", {32'd0, data_out}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Directed cases from the requirements.
      run_op(32'h8000_0000, 5'd8,  2'b10, 0);
      chk("sra_literal", {32'd0, data_out}, 64'hFF80_0000);
      run_op(32'h8000_0000, 5'd31, 2'b01, 0);
      chk("srl_literal", {32'd0, data_out}, 64'h0000_0001);
      run_op(32'h1234_5678, 5'd12, 2'b11, 0);
      chk("ror_literal", {32'd0, data_out}, 64'h6781_2345);
      run_op(32'h0000_0001, 5'd0,  2'b00, 0);
      run_op(32'hDEAD_BEEF, 5'd16, 2'b11, 5);

      // Reset during SHIFT discards the operation.
      @(negedge clock);
      in_valid = 1'b1;
      data_in  = 32'hFFFF_FFFF;
      shamt    = 5'd24;
      op       = 2'b00;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(posedge clock);
      #3;
      chk("mid_shift_busy", {63'd0, busy}, 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_data_out", {32'd0, data_out}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      run_op(32'h7FFF_FFFF, 5'd4, 2'b10, 0);
      chk("post_rst_sra", {32'd0, data_out}, 64'h07FF_FFFF);

      // Randomised operations against the reference model.
      for (int n = 0; n < 60; n++) begin
         run_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
